// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared state encoding and default constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Architectural zero register; never a real data dependency.
  localparam int XZR_IDX          = 31;
  localparam int MAX_WAIT_DEF     = 15;
  localparam int DRAIN_CYCLES_DEF = 3;

  // Controller state encoding, kept as plain constants so older blocks can share it.
  typedef logic [1:0] pipe_state_t;
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

endpackage

// File: rtl/hazard_detect.sv
// Purpose: combinational load-use and flag-dependency compare between the ID and EX stages.
// Latency: zero cycles (pure combinational).
// Backpressure: none; consumers decide how to stall. Macro PIPE_FLAG_FWD_EN turns flag hazards into forwarding.
module hazard_detect import pipe_ctrl_pkg::*; #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_is_bcond,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_sets_flags,
  output logic             lu_haz,
  output logic             fl_haz,
  output logic             flag_fwd
);

  logic flag_dep;

  // A load in EX feeding a register read in ID; XZR writes are discarded so never conflict.
  always_comb begin
    lu_haz = ex_mem_read && (ex_rd != REG_W'(XZR_IDX)) &&
             ((id_use_rn && (id_rn == ex_rd)) || (id_use_rm && (id_rm == ex_rd)));
  end

  // B.cond in ID needs the flags being produced by EX: either forward them or bubble.
  always_comb begin
    flag_dep = id_is_bcond & ex_sets_flags;
`ifdef PIPE_FLAG_FWD_EN
    fl_haz   = 1'b0;
    flag_fwd = flag_dep;
`else
    fl_haz   = flag_dep;
    flag_fwd = 1'b0;
`endif
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush/freeze controller for the 5-stage core (PC, IF/ID..MEM/WB banks, NZVC flags).
// Latency: Mealy outputs, zero-cycle from inputs; state and counters update on posedge clk.
// Backpressure: mem_busy freezes every bank; hazards insert one bubble. Macro PIPE_FLAG_FWD_EN enables flag forwarding.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int REG_W        = 5,
  parameter int MAX_WAIT     = MAX_WAIT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_is_bcond,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_sets_flags,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             flag_en,
  output logic             flag_fwd,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  pipe_state_t        state, ret_state, eff_state, nxt_state, nxt_ret;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               lu_haz, fl_haz;
  logic               freeze, drain_ld, drain_dec;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rn         (id_rn),
    .id_rm         (id_rm),
    .id_use_rn     (id_use_rn),
    .id_use_rm     (id_use_rm),
    .id_is_bcond   (id_is_bcond),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_sets_flags (ex_sets_flags),
    .lu_haz        (lu_haz),
    .fl_haz        (fl_haz),
    .flag_fwd      (flag_fwd)
  );

  // The cycle mem_busy drops already behaves as the state we froze from, so the freeze costs exactly the busy cycles.
  always_comb begin
    eff_state = ((state == ST_MEM_WAIT) && !mem_busy) ? ret_state : state;
  end

  // Output decode and next-state selection, highest priority first.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    nxt_state = eff_state;
    nxt_ret   = ret_state;
    freeze    = 1'b0;
    drain_ld  = 1'b0;
    drain_dec = 1'b0;
    if (reset) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      nxt_state = ST_RUN;
      nxt_ret   = ST_RUN;
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (mem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            freeze    = 1'b1;
            nxt_state = ST_MEM_WAIT;
            nxt_ret   = ST_RUN;
          end else if (ex_branch_taken) begin
            // Instruction in ID is squashed, so its hazards are moot.
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
          end else if (lu_haz || fl_haz) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end else if (halt_req) begin
            ifid_clr  = 1'b1;
            drain_ld  = 1'b1;
            nxt_state = ST_DRAIN;
          end
        end
        ST_MEM_WAIT: begin
          // Only reached here while mem_busy is still high.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
          freeze = 1'b1;
        end
        ST_DRAIN: begin
          if (mem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            freeze    = 1'b1;
            nxt_state = ST_MEM_WAIT;
            nxt_ret   = ST_DRAIN;
          end else begin
            pc_en    = 1'b0;
            ifid_clr = 1'b1;
            if (drain_cnt == '0) nxt_state = ST_HALTED;
            else                 drain_dec = 1'b1;
          end
        end
        default: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        end
      endcase
    end
  end

  // Flags only commit when the EX instruction actually advances into MEM.
  always_comb begin
    flag_en = ex_sets_flags & exmem_en & ~reset;
    halted  = (state == ST_HALTED) & ~reset;
  end

  // State, return state, wait/drain counters, sticky timeout and stall statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      ret_state    <= ST_RUN;
      wait_cnt     <= '0;
      drain_cnt    <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret;
      // Every frozen cycle counts toward the timeout, including the one that enters the wait.
      if (freeze) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WAIT_W'(MAX_WAIT - 1)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (drain_ld)       drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
      else if (drain_dec) drain_cnt <= drain_cnt - 1'b1;
      if (!pc_en && (state != ST_HALTED) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
